// File: rtl/fire_sequencer_if.sv
// Handshake bundle shared by the fire sequencer, its request source and the downstream timer.
// master = sequencer side, slave = environment (request source plus timer).
interface fire_sequencer_if;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic       fire_valid;
  logic [1:0] mode;
  logic       fire_ready;
  logic       done;

  modport master (
    input  req_valid, req_mode, fire_ready, done,
    output req_ready, fire_valid, mode
  );

  modport slave (
    output req_valid, req_mode, fire_ready, done,
    input  req_ready, fire_valid, mode
  );
endinterface

// File: rtl/fire_sequencer.sv
// Queues timer fire requests and issues them one at a time to a single-shot timer,
// enforcing an idle gap after each completion and flagging timers that never finish.
//   state        | meaning
//   ST_IDLE      | queue empty, nothing offered to the timer
//   ST_ISSUE     | head request offered (fire_valid=1) until the timer accepts it
//   ST_WAIT_DONE | timer running; timeout counter advancing
//   ST_GAP       | enforced idle cycles after done or timeout
module fire_sequencer #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 300
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fire_sequencer_if.master       bus,
  output logic [$clog2(DEPTH):0] pending,
  output logic [7:0]             issued,
  output logic                   timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL     = PW'(DEPTH);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP);
  localparam logic [8:0]    TMO_LAST = 9'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_GAP} state_t;

  state_t        state;
  state_t        after_gap;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    gap_cnt;
  logic [8:0]    tmo_cnt;
  logic          push;
  logic          pop;

  assign push      = bus.req_valid && bus.req_ready;
  assign pop       = (state == ST_ISSUE) && bus.fire_ready;
  assign after_gap = (pending != '0) ? ST_ISSUE : ST_IDLE;

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign bus.req_ready  = (pending != FULL);
  assign bus.fire_valid = (state == ST_ISSUE);
  assign bus.mode       = (state == ST_ISSUE) ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending     <= '0;
      issued      <= '0;
      timeout_err <= 1'b0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        issued <= issued + 8'd1;
      end
      if (push && !pop)      pending <= pending + PW'(1);
      else if (pop && !push) pending <= pending - PW'(1);

      case (state)
        ST_IDLE: begin
          if (pending != '0) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bus.fire_ready) begin
            tmo_cnt <= '0;
            state   <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 9'd1;
          // A done arriving on the timeout edge wins and leaves the error clear.
          if (bus.done || (tmo_cnt == TMO_LAST)) begin
            if (!bus.done) timeout_err <= 1'b1;
            if (GAP == 0) begin
              state <= after_gap;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= after_gap;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
